// File: rtl/token_pacer_pkg.sv
// Shared types and constants for the token pacer.
// Build option TOKEN_PACER_STATS_EN enables the fire statistics counter.
package token_pacer_pkg;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_GAP   = 1'b1
    } pacer_state_t;

    localparam int STATS_W = 32;

endpackage

// File: rtl/token_credit_ctr.sv
// Saturating up/down credit pool with sticky overflow flag.
// Clear restores INIT_CREDITS and drops any simultaneous increment.
module token_credit_ctr
    import token_pacer_pkg::*;
#(
    parameter int CREDIT_W     = 4,
    parameter int INIT_CREDITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [CREDIT_W-1:0] o_count,
    output logic                o_ovf
);

    localparam logic [CREDIT_W-1:0] MAX_CNT  = {CREDIT_W{1'b1}};
    localparam logic [CREDIT_W-1:0] INIT_CNT = CREDIT_W'(INIT_CREDITS);

    logic [CREDIT_W-1:0] r_count;
    logic                r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= INIT_CNT;
            r_ovf   <= 1'b0;
        end else if (i_clr) begin
            r_count <= INIT_CNT;
            r_ovf   <= 1'b0;
        end else if (i_inc && !i_dec) begin
            if (r_count == MAX_CNT) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/token_pacer.sv
// Credit- and gap-limited dequeue pacer for dataless token FIFOs.
// TOKEN_PACER_STATS_EN adds FIRE_COUNT output and STATS_CLR input.
module token_pacer
    import token_pacer_pkg::*;
#(
    parameter int CREDIT_W     = 4,
    parameter int INIT_CREDITS = 4,
    parameter int GAP_W        = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    input  logic                ENABLE,
    input  logic                EMPTY_N,
    output logic                DEQ,
    output logic                FIRE,
    input  logic                CREDIT,
    input  logic [GAP_W-1:0]    GAP,
    output logic [CREDIT_W-1:0] CREDITS,
    output logic                BUSY,
    output logic                ERR
`ifdef TOKEN_PACER_STATS_EN
    ,
    output logic [STATS_W-1:0]  FIRE_COUNT,
    input  logic                STATS_CLR
`endif
);

    pacer_state_t     r_state;
    pacer_state_t     w_state_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             w_fire;

    // RST gates fire so nothing is popped while reset is held
    assign w_fire = RST && !CLR && ENABLE && EMPTY_N
                 && (r_state == ST_READY) && (CREDITS != '0);

    assign FIRE = w_fire;
    assign DEQ  = w_fire;
    assign BUSY = (r_state == ST_GAP);

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        if (CLR) begin
            w_state_nxt = ST_READY;
            w_gap_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_READY: begin
                    if (w_fire && (GAP != '0)) begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = GAP;
                    end
                end
                ST_GAP: begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        w_state_nxt = ST_READY;
                        w_gap_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_READY;
                    w_gap_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_READY;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    token_credit_ctr #(
        .CREDIT_W     (CREDIT_W),
        .INIT_CREDITS (INIT_CREDITS)
    ) u_credit (
        .clk     (CLK),
        .rst_n   (RST),
        .i_clr   (CLR),
        .i_inc   (CREDIT),
        .i_dec   (w_fire),
        .o_count (CREDITS),
        .o_ovf   (ERR)
    );

`ifdef TOKEN_PACER_STATS_EN
    logic [STATS_W-1:0] r_fire_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_fire_cnt <= '0;
        end else if (CLR || STATS_CLR) begin
            r_fire_cnt <= '0;
        end else if (w_fire) begin
            r_fire_cnt <= r_fire_cnt + 1'b1;
        end
    end

    assign FIRE_COUNT = r_fire_cnt;
`endif

endmodule

// File: tb/tb_token_pacer.sv
// Directed self-checking bench for token_pacer.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_token_pacer;
    import token_pacer_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CLR = 1'b0;
    logic       ENABLE = 1'b0;
    logic       EMPTY_N = 1'b0;
    logic       DEQ;
    logic       FIRE;
    logic       CREDIT = 1'b0;
    logic [7:0] GAP = 8'd0;
    logic [3:0] CREDITS;
    logic       BUSY;
    logic       ERR;
`ifdef TOKEN_PACER_STATS_EN
    logic [31:0] FIRE_COUNT;
    logic        STATS_CLR = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    token_pacer #(
        .CREDIT_W     (4),
        .INIT_CREDITS (4),
        .GAP_W        (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .CLR     (CLR),
        .ENABLE  (ENABLE),
        .EMPTY_N (EMPTY_N),
        .DEQ     (DEQ),
        .FIRE    (FIRE),
        .CREDIT  (CREDIT),
        .GAP     (GAP),
        .CREDITS (CREDITS),
        .BUSY    (BUSY),
        .ERR     (ERR)
`ifdef TOKEN_PACER_STATS_EN
        ,
        .FIRE_COUNT (FIRE_COUNT),
        .STATS_CLR  (STATS_CLR)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        EMPTY_N = 1'b1;
        ENABLE = 1'b1;
        GAP = 8'd0;
        repeat (3) tick();
        #1;
        checks++;
        if (FIRE !== 1'b0 || DEQ !== 1'b0) begin
            failures++;
            $display("FAIL rst_fire got=%b/%b exp=0/0", FIRE, DEQ);
        end
        checks++;
        if (CREDITS !== 4'd4) begin
            failures++;
            $display("FAIL rst_credits got=%0d exp=4", CREDITS);
        end
        checks++;
        if (BUSY !== 1'b0 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy_err got=%b/%b exp=0/0", BUSY, ERR);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (FIRE !== 1'b1 || DEQ !== 1'b1) begin
            failures++;
            $display("FAIL rst_first_fire got=%b/%b exp=1/1", FIRE, DEQ);
        end
        EMPTY_N = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp;
        do_clr();
        GAP = 8'd0;
        EMPTY_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp = (i < 4);
            checks++;
            if (FIRE !== exp) begin
                failures++;
                $display("FAIL b2b_fire[%0d] got=%b exp=%b", i, FIRE, exp);
            end
            tick();
        end
        checks++;
        if (CREDITS !== 4'd0) begin
            failures++;
            $display("FAIL b2b_drained got=%0d exp=0", CREDITS);
        end
        CREDIT = 1'b1;
        tick();
        CREDIT = 1'b0;
        #1;
        checks++;
        if (FIRE !== 1'b1) begin
            failures++;
            $display("FAIL b2b_credit_fire got=%b exp=1", FIRE);
        end
        tick();
        #1;
        checks++;
        if (FIRE !== 1'b0 || CREDITS !== 4'd0) begin
            failures++;
            $display("FAIL b2b_after got=%b/%0d exp=0/0", FIRE, CREDITS);
        end
        EMPTY_N = 1'b0;
    endtask

    task automatic test_gap_spacing();
        logic ef;
        do_clr();
        GAP = 8'd3;
        EMPTY_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ef = (i % 4 == 0);
            CREDIT = ef;
            #1;
            checks++;
            if (FIRE !== ef || BUSY !== !ef) begin
                failures++;
                $display("FAIL gap[%0d] fire/busy got=%b/%b exp=%b/%b",
                         i, FIRE, BUSY, ef, !ef);
            end
            tick();
        end
        CREDIT = 1'b0;
        EMPTY_N = 1'b0;
        #1;
        checks++;
        if (CREDITS !== 4'd4) begin
            failures++;
            $display("FAIL gap_credits got=%0d exp=4", CREDITS);
        end
        GAP = 8'd0;
        repeat (4) tick();
    endtask

    task automatic test_simultaneous();
        do_clr();
        GAP = 8'd0;
        EMPTY_N = 1'b1;
        repeat (2) tick();
        CREDIT = 1'b1;
        #1;
        checks++;
        if (FIRE !== 1'b1 || CREDITS !== 4'd2) begin
            failures++;
            $display("FAIL sim_pre got=%b/%0d exp=1/2", FIRE, CREDITS);
        end
        tick();
        EMPTY_N = 1'b0;
        CREDIT = 1'b0;
        #1;
        checks++;
        if (CREDITS !== 4'd2) begin
            failures++;
            $display("FAIL sim_credits got=%0d exp=2", CREDITS);
        end
        CREDIT = 1'b1;
        repeat (13) tick();
        CREDIT = 1'b0;
        #1;
        checks++;
        if (CREDITS !== 4'd15 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL sat_fill got=%0d/%b exp=15/0", CREDITS, ERR);
        end
        CREDIT = 1'b1;
        tick();
        CREDIT = 1'b0;
        tick();
        checks++;
        if (CREDITS !== 4'd15 || ERR !== 1'b1) begin
            failures++;
            $display("FAIL sat_ovf got=%0d/%b exp=15/1", CREDITS, ERR);
        end
        CREDIT = 1'b1;
        do_clr();
        CREDIT = 1'b0;
        #1;
        checks++;
        if (CREDITS !== 4'd4 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL sat_clr got=%0d/%b exp=4/0", CREDITS, ERR);
        end
    endtask

    task automatic test_mid_gap_clr();
        do_clr();
        GAP = 8'd10;
        EMPTY_N = 1'b1;
        #1;
        checks++;
        if (FIRE !== 1'b1) begin
            failures++;
            $display("FAIL mg_fire got=%b exp=1", FIRE);
        end
        repeat (3) tick();
        CLR = 1'b1;
        #1;
        checks++;
        if (BUSY !== 1'b1 || FIRE !== 1'b0 || CREDITS !== 4'd3) begin
            failures++;
            $display("FAIL mg_in_gap got=%b/%b/%0d exp=1/0/3",
                     BUSY, FIRE, CREDITS);
        end
        tick();
        CLR = 1'b0;
        #1;
        checks++;
        if (BUSY !== 1'b0 || CREDITS !== 4'd4 || ERR !== 1'b0 || FIRE !== 1'b1) begin
            failures++;
            $display("FAIL mg_after_clr got=%b/%0d/%b/%b exp=0/4/0/1",
                     BUSY, CREDITS, ERR, FIRE);
        end
        CLR = 1'b1;
        #1;
        checks++;
        if (FIRE !== 1'b0) begin
            failures++;
            $display("FAIL clr_suppress got=%b exp=0", FIRE);
        end
        tick();
        CLR = 1'b0;
        repeat (2) tick();
        #1;
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL mg_rst_pre got=%b exp=1", BUSY);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (BUSY !== 1'b0 || CREDITS !== 4'd4 || FIRE !== 1'b0 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL mg_async_rst got=%b/%0d/%b/%b exp=0/4/0/0",
                     BUSY, CREDITS, FIRE, ERR);
        end
        tick();
        RST = 1'b1;
        #1;
        checks++;
        if (FIRE !== 1'b1) begin
            failures++;
            $display("FAIL mg_rst_release got=%b exp=1", FIRE);
        end
        EMPTY_N = 1'b0;
        GAP = 8'd0;
        tick();
    endtask

`ifdef TOKEN_PACER_STATS_EN
    task automatic test_stats();
        do_clr();
        GAP = 8'd0;
        EMPTY_N = 1'b1;
        CREDIT = 1'b1;
        repeat (7) tick();
        EMPTY_N = 1'b0;
        CREDIT = 1'b0;
        #1;
        checks++;
        if (FIRE_COUNT !== 32'd7) begin
            failures++;
            $display("FAIL stats_count got=%0d exp=7", FIRE_COUNT);
        end
        STATS_CLR = 1'b1;
        tick();
        STATS_CLR = 1'b0;
        #1;
        checks++;
        if (FIRE_COUNT !== 32'd0 || CREDITS !== 4'd4) begin
            failures++;
            $display("FAIL stats_clr got=%0d/%0d exp=0/4", FIRE_COUNT, CREDITS);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gap_spacing();
        test_simultaneous();
        test_mid_gap_clr();
`ifdef TOKEN_PACER_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/token_pacer.md
# token_pacer

Dequeue-side pacing stage for dataless token FIFOs (the depth-2, width-0 token queues used between BSV-generated workers). Watches the FIFO's EMPTY_N and pops one token at a time via DEQ. Each pop fires a one-cycle FIRE pulse downstream. Pops are gated by a downstream credit pool and a programmable minimum idle gap between fires, so bursty token producers are converted into a rate- and credit-limited event stream.

## Interface
- CREDIT_W, 4: credit counter width; pool saturates at 2^CREDIT_W-1.
- INIT_CREDITS, 4: credit count after reset/CLR; must be ≤ 2^CREDIT_W-1.
- GAP_W, 8: width of the GAP input and gap counter.
- CLK  in  1  sole clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-low (asserted when 0).
- CLR  in  1  synchronous clear; same state effect as reset.
- ENABLE  in  1  when 0, no new fires; in-progress gap keeps counting.
- EMPTY_N  in  1  from upstream token FIFO; 1 = at least one token present.
- DEQ  out  1  pop strobe to upstream FIFO; identical to FIRE.
- FIRE  out  1  one-cycle event pulse to downstream.
- CREDIT  in  1  one-cycle credit return from downstream; +1 credit.
- GAP  in  GAP_W  minimum idle cycles between consecutive fires; sampled in the fire cycle.
- CREDITS  out  CREDIT_W  current credit count.
- BUSY  out  1  1 while in GAP state.
- ERR  out  1  sticky: credit returned while pool saturated.

## Operation
- States: READY, GAP.
- fire = (state==READY) & EMPTY_N & ENABLE & (CREDITS!=0) & !CLR. DEQ = FIRE = fire, combinational from registered state and EMPTY_N/ENABLE/CLR/CREDITS; no path from CREDIT or GAP.
- READY: on fire with GAP==0, stay READY (back-to-back fires every cycle permitted). On fire with GAP!=0, load gap counter with GAP and go to GAP.
- GAP: counter decrements each cycle; at counter==1 return to READY. Exactly GAP cycles without FIRE between two fires.
- Credits: next = CREDITS - fire + CREDIT. Simultaneous fire and CREDIT leaves count unchanged. CREDIT at saturation (2^CREDIT_W-1) without fire is dropped and sets ERR. Counter never wraps; fire is impossible at 0.
- CLR (when RST deasserted): state←READY, gap counter←0, CREDITS←INIT_CREDITS, ERR←0. FIRE suppressed in the CLR cycle. CREDIT in the CLR cycle is discarded.
- Reset mid-gap or mid-burst: immediate return to reset values. No fire is lost or duplicated relative to EMPTY_N, because DEQ deasserts combinationally with state.

## Timing
- Reset values: state READY, CREDITS=INIT_CREDITS, BUSY=0, ERR=0, gap counter 0; FIRE/DEQ=0 while RST=0.
- Latency EMPTY_N↑ to FIRE: 0 cycles (same cycle) if READY, ENABLE and credits are available.
- CREDIT to usable credit: 1 cycle (registered).
- Fire spacing with GAP=g: fires at cycles t, t+g+1, t+2(g+1), … while tokens and credits last.
- ENABLE, GAP, CREDIT are sampled on the rising edge. GAP changes during GAP state have no effect until the next fire.

## Configuration
- TOKEN_PACER_STATS_EN defined: adds output FIRE_COUNT (32 bits) and input STATS_CLR. FIRE_COUNT increments on each fire, wraps at 2^32, resets to 0 on RST, CLR or STATS_CLR.
- Not defined: ports and counter absent; behaviour otherwise identical.

## Structure
- Shared package: state encoding constants (READY=1'b0, GAP=1'b1) and the 32-bit stats width constant.
- Credit pool is a natural sub-module, token_credit_ctr: saturating up/down counter with inc/dec/clr inputs, count output and overflow-sticky output. Parameterised by CREDIT_W and INIT_CREDITS.
- FSM, gap counter and optional stats counter live in token_pacer.

## Test plan
- Reset/defaults: hold RST=0 for 3 cycles with EMPTY_N=1 -> FIRE=0, CREDITS=4, BUSY=0, ERR=0. After release with ENABLE=1, GAP=0: FIRE in the first cycle.
- Back-to-back drain: EMPTY_N=1 constant, GAP=0, no CREDIT -> exactly 4 consecutive FIRE cycles, then CREDITS=0 and FIRE=0. One CREDIT pulse -> one more FIRE on the following cycle.
- Gap spacing: GAP=3, EMPTY_N=1, CREDIT pulsed every fire -> FIRE at cycles t, t+4, t+8, with BUSY=1 for the 3 cycles between.
- Simultaneous fire+CREDIT: CREDITS=2, fire and CREDIT in the same cycle -> CREDITS stays 2. At CREDITS=15 (CREDIT_W=4), CREDIT with no fire -> CREDITS stays 15, ERR=1 until CLR.
- Mid-gap CLR/reset: GAP=10, fire, then CLR at 3rd gap cycle -> BUSY=0, CREDITS=4, ERR=0 next cycle, FIRE=0 in CLR cycle, FIRE next cycle if EMPTY_N=1. Repeat with async RST=0 pulse between edges -> outputs at reset values immediately.
- Stats (TOKEN_PACER_STATS_EN): 7 fires -> FIRE_COUNT=7. STATS_CLR -> 0 next cycle, CREDITS unaffected.
